// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Define DOWN_COUNT_TIMER_AUTO_RELOAD_EN for periodic (auto-reload) mode.
module down_count_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o,
    output logic             tc_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            q_q      <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (stop_i) begin
            // Abort wins over everything; q keeps its value.
            state_d = IDLE;
        end else if (start_i) begin
            if (load_val_i != ZERO) begin
                q_d      = load_val_i;
                reload_d = load_val_i;
                state_d  = RUN;
            end else begin
                q_d     = ZERO;
                tc_d    = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && en_i) begin
            if (q_q > ONE) begin
                q_d = q_q - ONE;
            end else begin
                tc_d = 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                q_d     = reload_q;
                state_d = RUN;
`else
                q_d     = ZERO;
                state_d = IDLE;
`endif
            end
        end
    end

    assign q_o    = q_q;
    assign busy_o = (state_q == RUN);
    assign tc_o   = tc_q;

endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench for down_count_timer (WIDTH=3), vector table plus
// hand-written async-reset sequence.
module tb_down_count_timer;

    typedef struct {
        logic       start;
        logic [2:0] lv;
        logic       en;
        logic       stop;
        logic [2:0] q;
        logic       busy;
        logic       tc;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] q;
        logic       busy;
        logic       tc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] load_val;
    logic       en;
    logic       stop;
    logic [2:0] q;
    logic       busy;
    logic       tc;

    int checks;
    int failures;

    vec_t vecs[$];
    exp_t sb[$];

    down_count_timer #(.WIDTH(3)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .load_val_i(load_val),
        .en_i      (en),
        .stop_i    (stop),
        .q_o       (q),
        .busy_o    (busy),
        .tc_o      (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(
        logic s, logic [2:0] l, logic e, logic p,
        logic [2:0] eq, logic eb, logic et);
        vec_t v;
        v.start = s; v.lv = l; v.en = e; v.stop = p;
        v.q = eq; v.busy = eb; v.tc = et;
        vecs.push_back(v);
    endfunction

    task automatic cmp(string nm, int idx,
                       logic [2:0] eq, logic eb, logic et);
        checks++;
        if (q !== eq || busy !== eb || tc !== et) begin
            failures++;
            $display("FAIL %s[%0d]: got q=%0d busy=%b tc=%b, want q=%0d busy=%b tc=%b",
                     nm, idx, q, busy, tc, eq, eb, et);
        end
    endtask

    task automatic drive(logic s, logic [2:0] l, logic e, logic p);
        start = s; load_val = l; en = e; stop = p;
    endtask

    initial begin
        exp_t e;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0);

        // test 1: idle after reset
        add(0,0,0,0, 0,0,0);
        add(0,0,0,0, 0,0,0);
        // test 2: load 5, en steady
        add(1,5,1,0, 5,1,0);
        add(0,0,1,0, 4,1,0);
        add(0,0,1,0, 3,1,0);
        add(0,0,1,0, 2,1,0);
        add(0,0,1,0, 1,1,0);
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
        add(0,0,1,0, 5,1,1);
        add(0,0,1,0, 4,1,0);
        add(0,0,0,1, 4,0,0);
`else
        add(0,0,1,0, 0,0,1);
        add(0,0,1,0, 0,0,0);
        add(0,0,0,1, 0,0,0);
`endif
        // test 3: en toggling
        add(1,5,0,0, 5,1,0);
        add(0,0,1,0, 4,1,0);
        add(0,0,0,0, 4,1,0);
        add(0,0,1,0, 3,1,0);
        add(0,0,0,0, 3,1,0);
        add(0,0,1,0, 2,1,0);
        add(0,0,0,0, 2,1,0);
        add(0,0,1,0, 1,1,0);
        add(0,0,0,0, 1,1,0);
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
        add(0,0,1,0, 5,1,1);
        add(0,0,0,0, 5,1,0);
        add(0,0,0,1, 5,0,0);
`else
        add(0,0,1,0, 0,0,1);
        add(0,0,0,0, 0,0,0);
        add(0,0,0,1, 0,0,0);
`endif
        // test 4: stop at 3, en ignored in idle
        add(1,7,1,0, 7,1,0);
        add(0,0,1,0, 6,1,0);
        add(0,0,1,0, 5,1,0);
        add(0,0,1,0, 4,1,0);
        add(0,0,1,0, 3,1,0);
        add(0,0,1,1, 3,0,0);
        add(0,0,1,0, 3,0,0);
        // test 4b: retrigger at 4 with 6
        add(1,7,0,0, 7,1,0);
        add(0,0,1,0, 6,1,0);
        add(0,0,1,0, 5,1,0);
        add(0,0,1,0, 4,1,0);
        add(1,6,1,0, 6,1,0);
        add(0,0,1,0, 5,1,0);
        add(0,0,0,1, 5,0,0);
        // test 6: zero load from idle
        add(1,0,0,0, 0,0,1);
        add(0,0,0,0, 0,0,0);
        // stop beats terminal at q==1
        add(1,2,0,0, 2,1,0);
        add(0,0,1,0, 1,1,0);
        add(0,0,1,1, 1,0,0);
        add(0,0,0,0, 1,0,0);
        // zero retrigger while running
        add(1,3,0,0, 3,1,0);
        add(1,0,1,0, 0,0,1);
        add(0,0,0,0, 0,0,0);
        // stop beats start
        add(1,4,0,0, 4,1,0);
        add(1,6,1,1, 4,0,0);
        add(0,0,0,0, 4,0,0);

        #2;
        cmp("in_reset", 0, 0, 0, 0);
        #8;
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].lv, vecs[i].en, vecs[i].stop);
            e.idx = i; e.q = vecs[i].q;
            e.busy = vecs[i].busy; e.tc = vecs[i].tc;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            cmp("vec", e.idx, e.q, e.busy, e.tc);
        end

        // test 5: async reset between edges at q==2
        @(negedge clk);
        drive(1, 5, 0, 0);
        @(posedge clk); #1;
        cmp("ar_load", 0, 5, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 0);
            @(posedge clk); #1;
            cmp("ar_cnt", k, 3'(4 - k), 1, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        cmp("ar_hold", 0, 2, 1, 0);
        #1;
        rst = 1'b1;
        #1;
        cmp("ar_async", 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        cmp("ar_after", 0, 0, 0, 0);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_left: got %0d entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
